// File: rtl/sync_set_ctrl_pkg.sv
// Shared settings for the ECAT sync-time load path.
// Holds the controller state type and constants common with the synchronizer.
package sync_set_ctrl_pkg;

    // 20.48 MHz CLK x 500 us ECAT sync period
    localparam int unsigned ECAT_SYNC_BASE_CNT = 10240;
    localparam int unsigned ECAT_SYNC_BASE_NS  = 500000;

    // Width of the SYNC interval measurement
    localparam int unsigned IVL_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        SETTLE
    } sync_ctrl_state_t;

endpackage

// File: rtl/sync_interval_monitor.sv
// Measures SYNC spacing and reports LOCKED once enough good intervals follow a load.
// Ports: CLK, RST (async high), SYNC, CLEAR (accepted load request),
//        LOADED_OK (last load finished) -> LOCKED, LAST_INTERVAL (cycles).
module sync_interval_monitor
    import sync_set_ctrl_pkg::*;
#(
    parameter int unsigned BASE_CNT   = ECAT_SYNC_BASE_CNT,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SYNC,
    input  logic             CLEAR,
    input  logic             LOADED_OK,
    output logic             LOCKED,
    output logic [IVL_W-1:0] LAST_INTERVAL
);

    localparam int unsigned GC_W = $clog2(LOCK_COUNT + 1);

    localparam logic [IVL_W-1:0] IVL_MAX = '1;
    localparam logic [IVL_W-1:0] GOOD_LO = IVL_W'(BASE_CNT - TOL);
    localparam logic [IVL_W-1:0] GOOD_HI = IVL_W'(BASE_CNT + TOL);
    // ivl steps onto BASE_CNT+TOL on the edge after this value
    localparam logic [IVL_W-1:0] MISS_AT = IVL_W'(BASE_CNT + TOL - 1);
    localparam logic [GC_W-1:0]  GC_FULL = GC_W'(LOCK_COUNT);

    if (LOCK_COUNT == 0 || TOL > BASE_CNT ||
        BASE_CNT + TOL >= 2 ** IVL_W) begin : g_param_check
        $error("sync_interval_monitor: BASE_CNT/TOL/LOCK_COUNT out of range");
    end

    logic [IVL_W-1:0] ivl;
    logic [IVL_W-1:0] ivl_inc;
    logic             first;
    logic [GC_W-1:0]  good_cnt;
    logic [GC_W-1:0]  good_nxt;
    logic             good;
    logic             missing;

    always_comb begin
        // ivl_inc is the interval length if SYNC lands this cycle
        ivl_inc  = (ivl == IVL_MAX) ? IVL_MAX : ivl + 1'b1;
        good     = (ivl_inc >= GOOD_LO) && (ivl_inc <= GOOD_HI);
        missing  = first && !SYNC && (ivl == MISS_AT);
        good_nxt = good_cnt;
        if (CLEAR) begin
            good_nxt = '0;
        end else if (SYNC && first) begin
            if (!good) begin
                good_nxt = '0;
            end else if (good_cnt != GC_FULL) begin
                good_nxt = good_cnt + 1'b1;
            end
        end else if (missing) begin
            good_nxt = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ivl           <= '0;
            first         <= 1'b0;
            good_cnt      <= '0;
            LOCKED        <= 1'b0;
            LAST_INTERVAL <= '0;
        end else begin
            ivl <= SYNC ? '0 : ivl_inc;
            if (CLEAR) begin
                first <= 1'b0;
            end else if (SYNC) begin
                first <= 1'b1;
            end
            if (SYNC && first && !CLEAR) begin
                LAST_INTERVAL <= ivl_inc;
            end
            good_cnt <= good_nxt;
            LOCKED   <= LOADED_OK && (good_nxt == GC_FULL);
        end
    end

endmodule

// File: rtl/sync_set_ctrl.sv
// Sequences a CPU sync-time load into the synchronizer: SET pulse, wait for the
// consuming SYNC, settle, then DONE or TIMEOUT_ERR; also reports SYNC lock.
// Ports: CLK, RST (async high), REQ/REQ_TIME (CPU), SYNC (synchronizer),
//        SYNC_SET/SYNC_TIME (to synchronizer), BUSY, DONE, TIMEOUT_ERR,
//        LOCKED, LAST_INTERVAL (status to CPU).
module sync_set_ctrl
    import sync_set_ctrl_pkg::*;
#(
    parameter int unsigned BASE_CNT        = ECAT_SYNC_BASE_CNT,
    parameter int unsigned TOL             = 2,
    parameter int unsigned TIMEOUT_PERIODS = 4,
    parameter int unsigned SETTLE_CYCLES   = 8,
    parameter int unsigned LOCK_COUNT      = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [63:0]      REQ_TIME,
    input  logic             SYNC,
    output logic             SYNC_SET,
    output logic [63:0]      SYNC_TIME,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT_ERR,
    output logic             LOCKED,
    output logic [IVL_W-1:0] LAST_INTERVAL
);

    localparam int unsigned TMO_CYCLES = TIMEOUT_PERIODS * BASE_CNT;
    localparam int unsigned TMO_W      = $clog2(TMO_CYCLES);
    localparam int unsigned STL_W      = $clog2(SETTLE_CYCLES);

    // Expire on the edge where the count would reach TMO_CYCLES-1
    localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TMO_CYCLES - 2);
    // The consuming SYNC edge is the first settle cycle
    localparam logic [STL_W-1:0] STL_FIRE = STL_W'(SETTLE_CYCLES - 2);

    if (SETTLE_CYCLES < 2 || TMO_CYCLES < 2) begin : g_param_check
        $error("sync_set_ctrl: SETTLE_CYCLES and timeout must be >= 2");
    end

    sync_ctrl_state_t state, state_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
    logic [STL_W-1:0] stl_cnt, stl_cnt_d;
    logic             loaded_ok, loaded_ok_d;
    logic             set_d;
    logic [63:0]      time_d;
    logic             busy_d;
    logic             done_d;
    logic             terr_d;
    logic             clear;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            stl_cnt     <= '0;
            loaded_ok   <= 1'b0;
            SYNC_SET    <= 1'b0;
            SYNC_TIME   <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state       <= state_d;
            tmo_cnt     <= tmo_cnt_d;
            stl_cnt     <= stl_cnt_d;
            loaded_ok   <= loaded_ok_d;
            SYNC_SET    <= set_d;
            SYNC_TIME   <= time_d;
            BUSY        <= busy_d;
            DONE        <= done_d;
            TIMEOUT_ERR <= terr_d;
        end
    end

    always_comb begin
        state_d     = state;
        tmo_cnt_d   = tmo_cnt;
        stl_cnt_d   = stl_cnt;
        loaded_ok_d = loaded_ok;
        set_d       = 1'b0;
        time_d      = SYNC_TIME;
        busy_d      = BUSY;
        done_d      = 1'b0;
        terr_d      = TIMEOUT_ERR;
        clear       = 1'b0;
        unique case (state)
            IDLE: begin
                // A SYNC in this same cycle is the one that latches SET,
                // so it is never taken as the consuming SYNC.
                if (REQ) begin
                    state_d     = WAIT_SYNC;
                    tmo_cnt_d   = '0;
                    set_d       = 1'b1;
                    time_d      = REQ_TIME;
                    busy_d      = 1'b1;
                    terr_d      = 1'b0;
                    loaded_ok_d = 1'b0;
                    clear       = 1'b1;
                end
            end
            WAIT_SYNC: begin
                if (SYNC) begin
                    state_d   = SETTLE;
                    stl_cnt_d = '0;
                end else if (tmo_cnt == TMO_FIRE) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (stl_cnt == STL_FIRE) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    loaded_ok_d = 1'b1;
                end else begin
                    stl_cnt_d = stl_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sync_interval_monitor #(
        .BASE_CNT   (BASE_CNT),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_monitor (
        .CLK           (CLK),
        .RST           (RST),
        .SYNC          (SYNC),
        .CLEAR         (clear),
        .LOADED_OK     (loaded_ok),
        .LOCKED        (LOCKED),
        .LAST_INTERVAL (LAST_INTERVAL)
    );

endmodule

// File: doc/sync_set_ctrl.md
Name: sync_set_ctrl

Overview:
Controller that sequences the EtherCAT sync-time load into the synchronizer. It accepts a CPU request carrying a new ECAT sync time and issues the one-cycle SET with the time value. It waits for the synchronizer to consume the SET on the next SYNC, then waits out the arithmetic settle window and reports DONE or TIMEOUT. A sync-interval monitor in the same block measures SYNC spacing and drives a LOCKED status back to the CPU register map.

Parameters:
BASE_CNT, 10240, nominal CLK cycles between SYNC pulses (20.48 MHz × 500 µs)
TOL, 2, allowed |interval − BASE_CNT| in cycles
TIMEOUT_PERIODS, 4, SYNC periods to wait for the consuming SYNC before TIMEOUT
SETTLE_CYCLES, 8, cycles after the consuming SYNC before DONE; must be ≥ synchronizer add/sub latency + 2
LOCK_COUNT, 3, consecutive good intervals required for LOCKED

Ports:
CLK  in  1  system clock (20.48 MHz domain)
RST  in  1  asynchronous, active-high reset
REQ  in  1  single-cycle load request from the CPU register block
REQ_TIME  in  64  requested ECAT sync time in ns
SYNC  in  1  synchronizer SYNC output, one cycle per ECAT sync
SYNC_SET  out  1  to SYNC_SETTINGS.SET, one-cycle pulse
SYNC_TIME  out  64  to SYNC_SETTINGS.ECAT_SYNC_TIME
BUSY  out  1  load in progress
DONE  out  1  one-cycle pulse when the load completes
TIMEOUT_ERR  out  1  sticky; no consuming SYNC arrived in time
LOCKED  out  1  SYNC spacing stable after a successful load
LAST_INTERVAL  out  18  last measured SYNC interval in cycles

Behaviour:
- Reset (async assert, sync release): every output is 0, FSM is IDLE, and all counters, the first flag and loaded_ok are 0.
- FSM states: IDLE, WAIT_SYNC, SETTLE.
- IDLE, REQ=1:
  - In the next cycle: SYNC_TIME ← REQ_TIME, SYNC_SET=1 for exactly that cycle, BUSY=1, TIMEOUT_ERR=0, LOCKED=0, good_cnt=0, loaded_ok=0.
  - FSM → WAIT_SYNC and the timeout counter clears.
- SYNC in the same cycle as the REQ sample is not the consuming SYNC. The synchronizer latches SET on that edge, so WAIT_SYNC only reacts to later SYNC pulses.
- REQ while BUSY is ignored. SYNC_TIME stays stable from load until the next accepted REQ.
- WAIT_SYNC:
  - SYNC=1 → SETTLE, settle counter cleared.
  - Otherwise the timeout counter increments. At TIMEOUT_PERIODS·BASE_CNT − 1 (40959): TIMEOUT_ERR=1, BUSY=0, → IDLE.
- SETTLE:
  - Counter counts SETTLE_CYCLES. On the last count: DONE=1 for one cycle, BUSY=0, loaded_ok=1, → IDLE.
  - Any SYNC during SETTLE is ignored by the FSM and still feeds the monitor.
- Monitor, independent of the FSM:
  - ivl counter increments every cycle and saturates at 2^18−1.
  - On SYNC: LAST_INTERVAL ← ivl+1 (cycles since the previous SYNC), ivl ← 0.
  - The first SYNC after reset or after an accepted REQ only sets the first flag; LAST_INTERVAL is not updated.
  - good interval: BASE_CNT−TOL ≤ interval ≤ BASE_CNT+TOL. good_cnt saturates at LOCK_COUNT.
  - bad interval: good_cnt=0, LOCKED=0.
  - Missing SYNC: when ivl reaches BASE_CNT+TOL with the first flag set, good_cnt=0 and LOCKED=0 on that cycle.
  - LOCKED=1 iff good_cnt==LOCK_COUNT and loaded_ok. It updates one cycle after the qualifying SYNC.
- Width rules:
  - The timeout counter is $clog2(TIMEOUT_PERIODS·BASE_CNT) bits wide.
  - The interval comparison uses unsigned 18-bit arithmetic; BASE_CNT−TOL must not underflow (elaboration assertion).
- Mid-operation reset returns to IDLE with SYNC_SET=0. The synchronizer may already hold a pending set; software re-issues REQ.

Decomposition:
- Package settings gains:
  - sync_ctrl_state_t enum (IDLE, WAIT_SYNC, SETTLE)
  - constants ECAT_SYNC_BASE_CNT=10240 and ECAT_SYNC_BASE_NS=500000, shared with the synchronizer instead of local copies
- Sub-module sync_interval_monitor holds the ivl counter, first flag, good_cnt and LAST_INTERVAL. It has ports CLK, RST, SYNC, CLEAR, LOADED_OK → LOCKED, LAST_INTERVAL.
- The FSM stays in sync_set_ctrl.

Test Plan:
- REQ with REQ_TIME=0x0000_0001_DCD6_5000, SYNC every 10240 cycles: one SYNC_SET pulse, SYNC_TIME equals REQ_TIME; DONE exactly 8 cycles after the first SYNC following the set; BUSY high from REQ+1 to DONE.
- REQ with SYNC held low: TIMEOUT_ERR rises 40959 cycles after entering WAIT_SYNC, BUSY falls, no DONE; the next REQ clears TIMEOUT_ERR.
- REQ asserted coincident with SYNC: that SYNC is ignored; DONE follows the next SYNC + 8 cycles.
- After DONE, intervals 10240, 10241, 10239: LOCKED rises 1 cycle after the third SYNC. Then one interval of 10250: LOCKED drops and LAST_INTERVAL=10250.
- LOCKED, then SYNC stops: LOCKED drops when ivl=10242. Second REQ while BUSY: no second SYNC_SET and SYNC_TIME unchanged.
- RST asserted asynchronously mid-SETTLE: all outputs 0 immediately; no DONE after release.
